block_fetch: RTL and testbench
==============================

Name: block_fetch

Overview:
- Read-side consumer of the watermarking register bank; starts when the bank's CTRL start bit rises.
- Loads configuration registers 0x01–0x09 and validates them.
- Streams co-located primary/watermark pixel pairs to the block-processing datapath in MxM block order, with a valid/ready handshake.
- Sole reader of the bank while start=1; the bus master owns bank writes.

Parameters:
- Amba_Word, 16, bank data width.
- Amba_Addr_Depth, 20, bank address width is Amba_Addr_Depth+1.
- Max_Np, 720, largest legal PrimarySize.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  CTRL bit 0 from the register bank.
- rd_addr  out  Amba_Addr_Depth+1  bank read address.
- rd_data  in  Amba_Word  bank read data, valid exactly 1 clk after rd_addr is presented.
- white_pixel, edge_thr, a_min, a_max, b_min, b_max  out  Amba_Word each  latched config (0x01, 0x05–0x09).
- np_size, block_size  out  Amba_Word each  latched PrimarySize (0x02), BlockSize (0x04).
- px_valid  out  1  pixel pair available.
- px_ready  in  1  consumer accepts pair when px_valid&&px_ready.
- px_primary, px_wmark  out  Amba_Word each  pixel pair.
- px_blk_first, px_blk_last  out  1  first/last pixel of current MxM block.
- px_last  out  1  final pixel of the image.
- busy  out  1  high in LOAD, CHECK, FETCH_P, FETCH_W, PRESENT.
- done  out  1  level; image fully streamed.
- cfg_err  out  1  level; configuration rejected.

Behaviour:
- Reset (rst=0): FSM=IDLE; every output 0 except white_pixel=255; rd_addr=0.
- start edge detect: 1-flop history of start; rising edge in IDLE -> LOAD.
- LOAD: issue rd_addr 0x01..0x09 on consecutive cycles; capture rd_data one cycle later into the matching register. Exits after 10 cycles -> CHECK.
- CHECK (1 cycle): with Np=0x02, Nw=0x03, M=0x04, cfg_err when any of:
  - Np==0
  - Np>Max_Np
  - M==0
  - M>Np
  - Np mod M != 0
  - Nw != Np
  - Error path -> ERR. Otherwise latch NN = Np*Np (21-bit) -> FETCH_P.
- Address rule: pixel at image row y, col x has idx = y*Np + x. Primary address = 0x0A+idx; watermark address = 0x0A+NN+idx.
- Traversal order:
  - Blocks in row-major order (block row br, block col bc).
  - Inside each block, rows r, then cols c, all 0..M-1.
  - y = br*M+r, x = bc*M+c.
  - Address update is incremental; no per-pixel multiplier.
- FETCH_P: drive primary address. FETCH_W: capture px_primary, drive watermark address. PRESENT: capture px_wmark, assert px_valid with flags, hold all px_* stable until px_ready.
- On handshake:
  - Not last pixel -> FETCH_P with advanced position. Throughput: 1 pair per 3 clk with px_ready=1.
  - Last pixel -> DONE.
- Flags:
  - px_blk_first when r=c=0.
  - px_blk_last when r=c=M-1.
  - px_last when px_blk_last and br=bc=Np/M-1.
  - M==Np gives a single block with px_last on pixel NN-1. M==1 gives blk_first=blk_last=1 on every pixel.
- DONE: done=1, busy=0. ERR: cfg_err=1, busy=0. Both hold until start=0 -> IDLE, which clears done and cfg_err. Config outputs keep their last values.
- start falling in any busy state: abort to IDLE next edge. px_valid drops immediately, no handshake completes, counters clear. A later rising start restarts from LOAD.
- start held high after DONE/ERR never restarts; requires 0 then 1.
- rst asserted mid-operation: immediate return to reset values.

Decomposition:
- Shared package (watermark_pkg):
  - Register-map constants: CTRL=0x00, WHITE=0x01, NP=0x02, NW=0x03, BLK=0x04, EDGE=0x05, AMIN..BMAX=0x06..0x09, PIX_BASE=0x0A.
  - MAX_NP.
  - FSM state enum {IDLE, LOAD, CHECK, FETCH_P, FETCH_W, PRESENT, DONE, ERR}.
- One natural sub-module: block_addr_gen. Holds the br/bc/r/c counters and the incremental idx. Provides advance, clear, idx, first/last flags.

Test Plan:
- Np=Nw=4, M=2, px_ready=1 -> 16 pairs in block order.
  - idx sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - Watermark reads at 0x1A+idx.
  - px_last only on idx 15; done=1.
- Same config, px_ready low 5 cycles on 3rd pair -> pair held stable, no duplicate or skipped pixel, total still 16.
- M=3, Np=4 -> cfg_err=1 after 11 cycles, px_valid never asserted. start=0 -> cfg_err=0, IDLE.
- Np=Nw=2, M=1 -> 4 pairs, each with blk_first=blk_last=1. Np=M=2 -> one block, px_last on idx 3.
- Drop start after 5 handshakes -> px_valid=0 next cycle, busy=0. Re-raise start -> full restream from idx 0.
- Async rst low mid-PRESENT -> px_valid=0, white_pixel=255, all other outputs 0 without a clock edge.

Source files
------------

// File: rtl/watermark_pkg.sv
// rtl/watermark_pkg.sv - register map, limits and fetch FSM states shared by the watermark blocks
package watermark_pkg;

    localparam int unsigned REG_CTRL  = 'h00;
    localparam int unsigned REG_WHITE = 'h01;
    localparam int unsigned REG_NP    = 'h02;
    localparam int unsigned REG_NW    = 'h03;
    localparam int unsigned REG_BLK   = 'h04;
    localparam int unsigned REG_EDGE  = 'h05;
    localparam int unsigned REG_AMIN  = 'h06;
    localparam int unsigned REG_AMAX  = 'h07;
    localparam int unsigned REG_BMIN  = 'h08;
    localparam int unsigned REG_BMAX  = 'h09;
    localparam int unsigned PIX_BASE  = 'h0A;

    localparam int unsigned MAX_NP = 720;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        FETCH_P,
        FETCH_W,
        PRESENT,
        DONE,
        ERR
    } fetch_state_e;

endpackage

// File: rtl/block_addr_gen.sv
// rtl/block_addr_gen.sv - MxM block-order pixel walker producing image index and block flags
module block_addr_gen #(
    parameter int unsigned WordW = 16,
    parameter int unsigned IdxW  = 21
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [WordW-1:0] np_i,
    input  logic [WordW-1:0] m_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             blk_first_o,
    output logic             blk_last_o,
    output logic             last_o
);

    // bx/by are the pixel origins of the current block (bc*M, br*M)
    logic [WordW-1:0] r_q, c_q, bx_q, by_q;
    logic [IdxW-1:0]  blk_base_q, row_base_q, idx_q;
    logic [WordW-1:0] m_last;
    logic             row_end, blk_end, bcol_end, brow_end;
    logic [IdxW-1:0]  next_row, next_blk, next_idx;

    assign m_last   = m_i - 1'b1;
    assign row_end  = (c_q == m_last);
    assign blk_end  = row_end && (r_q == m_last);
    assign bcol_end = ((bx_q + m_i) == np_i);
    assign brow_end = ((by_q + m_i) == np_i);
    assign next_row = row_base_q + IdxW'(np_i);
    assign next_blk = blk_base_q + IdxW'(m_i);
    assign next_idx = idx_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q        <= '0;
            c_q        <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            blk_base_q <= '0;
            row_base_q <= '0;
            idx_q      <= '0;
        end else if (clear_i) begin
            r_q        <= '0;
            c_q        <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            blk_base_q <= '0;
            row_base_q <= '0;
            idx_q      <= '0;
        end else if (advance_i) begin
            if (!row_end) begin
                c_q   <= c_q + 1'b1;
                idx_q <= next_idx;
            end else if (!blk_end) begin
                c_q        <= '0;
                r_q        <= r_q + 1'b1;
                row_base_q <= next_row;
                idx_q      <= next_row;
            end else if (!bcol_end) begin
                c_q        <= '0;
                r_q        <= '0;
                bx_q       <= bx_q + m_i;
                blk_base_q <= next_blk;
                row_base_q <= next_blk;
                idx_q      <= next_blk;
            end else begin
                // last pixel of a block row is (by+M-1)*Np+Np-1, so +1 is the next block row base
                c_q        <= '0;
                r_q        <= '0;
                bx_q       <= '0;
                by_q       <= by_q + m_i;
                blk_base_q <= next_idx;
                row_base_q <= next_idx;
                idx_q      <= next_idx;
            end
        end
    end

    assign idx_o       = idx_q;
    assign blk_first_o = (r_q == '0) && (c_q == '0);
    assign blk_last_o  = blk_end;
    assign last_o      = blk_end && bcol_end && brow_end;

endmodule

// File: rtl/block_fetch.sv
// rtl/block_fetch.sv - loads and validates watermark config, then streams primary/watermark pixel pairs in block order
module block_fetch
    import watermark_pkg::*;
#(
    parameter int unsigned Amba_Word       = 16,
    parameter int unsigned Amba_Addr_Depth = 20,
    parameter int unsigned Max_Np          = MAX_NP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [Amba_Addr_Depth:0] rd_addr,
    input  logic [Amba_Word-1:0]     rd_data,
    output logic [Amba_Word-1:0]     white_pixel,
    output logic [Amba_Word-1:0]     edge_thr,
    output logic [Amba_Word-1:0]     a_min,
    output logic [Amba_Word-1:0]     a_max,
    output logic [Amba_Word-1:0]     b_min,
    output logic [Amba_Word-1:0]     b_max,
    output logic [Amba_Word-1:0]     np_size,
    output logic [Amba_Word-1:0]     block_size,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [Amba_Word-1:0]     px_primary,
    output logic [Amba_Word-1:0]     px_wmark,
    output logic                     px_blk_first,
    output logic                     px_blk_last,
    output logic                     px_last,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int unsigned W  = Amba_Word;
    localparam int unsigned AW = Amba_Addr_Depth + 1;

    fetch_state_e state_q, state_d;
    logic         start_prev_q;
    logic [3:0]   load_cnt_q;
    logic [W-1:0] white_q, np_q, nw_q, blk_q, edge_q, amin_q, amax_q, bmin_q, bmax_q;
    logic [AW-1:0] nn_q;
    logic [W-1:0] primary_q, wmark_q;
    logic         wm_live_q;
    logic [W-1:0] np_rem;
    logic         cfg_bad, handshake, advance, clear;
    logic [AW-1:0] idx;
    logic         gen_first, gen_blk_last, gen_last;

    assign np_rem  = (blk_q == '0) ? '0 : (np_q % blk_q);
    assign cfg_bad = (np_q == '0) || (np_q > W'(Max_Np)) || (blk_q == '0) ||
                     (blk_q > np_q) || (np_rem != '0) || (nw_q != np_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        cfg_err  = 1'b0;
        px_valid = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE:    if (start && !start_prev_q) state_d = LOAD;
            LOAD:    begin
                busy = 1'b1;
                if (load_cnt_q == 4'(REG_BMAX)) state_d = CHECK;
            end
            CHECK:   begin
                busy    = 1'b1;
                state_d = cfg_bad ? ERR : FETCH_P;
            end
            FETCH_P: begin
                busy    = 1'b1;
                state_d = FETCH_W;
            end
            FETCH_W: begin
                busy    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                busy     = 1'b1;
                px_valid = start;
                if (px_ready) state_d = gen_last ? DONE : FETCH_P;
            end
            DONE:    begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            ERR:     begin
                cfg_err = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // dropping start aborts any active phase without completing a handshake
        if (busy && !start) state_d = IDLE;
    end

    always_comb begin
        rd_addr = AW'(REG_CTRL);
        case (state_q)
            LOAD:    if (load_cnt_q < 4'(REG_BMAX)) rd_addr = AW'(load_cnt_q) + AW'(1);
            FETCH_P: rd_addr = AW'(PIX_BASE) + idx;
            FETCH_W,
            PRESENT: rd_addr = AW'(PIX_BASE) + nn_q + idx;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_prev_q <= 1'b0;
            load_cnt_q   <= '0;
            white_q      <= W'(255);
            np_q         <= '0;
            nw_q         <= '0;
            blk_q        <= '0;
            edge_q       <= '0;
            amin_q       <= '0;
            amax_q       <= '0;
            bmin_q       <= '0;
            bmax_q       <= '0;
            nn_q         <= '0;
            primary_q    <= '0;
            wmark_q      <= '0;
            wm_live_q    <= 1'b0;
        end else begin
            start_prev_q <= start;
            load_cnt_q   <= (state_q == LOAD) ? load_cnt_q + 4'd1 : 4'd0;
            // rd_data in LOAD cycle k answers the address issued in cycle k-1, i.e. register k
            if (state_q == LOAD) begin
                case (load_cnt_q)
                    4'(REG_WHITE): white_q <= rd_data;
                    4'(REG_NP):    np_q    <= rd_data;
                    4'(REG_NW):    nw_q    <= rd_data;
                    4'(REG_BLK):   blk_q   <= rd_data;
                    4'(REG_EDGE):  edge_q  <= rd_data;
                    4'(REG_AMIN):  amin_q  <= rd_data;
                    4'(REG_AMAX):  amax_q  <= rd_data;
                    4'(REG_BMIN):  bmin_q  <= rd_data;
                    4'(REG_BMAX):  bmax_q  <= rd_data;
                    default: ;
                endcase
            end
            if (state_q == CHECK) nn_q <= AW'(np_q) * AW'(np_q);
            if (state_q == FETCH_W) primary_q <= rd_data;
            wm_live_q <= (state_q == FETCH_W) && start;
            if (wm_live_q) wmark_q <= rd_data;
        end
    end

    assign handshake = px_valid && px_ready;
    assign advance   = handshake && !gen_last;
    assign clear     = (state_q == IDLE) || (state_q == LOAD);

    block_addr_gen #(
        .WordW (W),
        .IdxW  (AW)
    ) u_addr_gen (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (clear),
        .advance_i   (advance),
        .np_i        (np_q),
        .m_i         (blk_q),
        .idx_o       (idx),
        .blk_first_o (gen_first),
        .blk_last_o  (gen_blk_last),
        .last_o      (gen_last)
    );

    assign white_pixel  = white_q;
    assign np_size      = np_q;
    assign block_size   = blk_q;
    assign edge_thr     = edge_q;
    assign a_min        = amin_q;
    assign a_max        = amax_q;
    assign b_min        = bmin_q;
    assign b_max        = bmax_q;
    assign px_primary   = primary_q;
    // the watermark word is live on rd_data during the first PRESENT cycle, then held locally
    assign px_wmark     = wm_live_q ? rd_data : wmark_q;
    assign px_blk_first = px_valid && gen_first;
    assign px_blk_last  = px_valid && gen_blk_last;
    assign px_last      = px_valid && gen_last;

endmodule

// File: tb/tb_block_fetch.sv
// tb/tb_block_fetch.sv - directed scoreboard bench for block_fetch with a one-cycle-latency bank model
module tb_block_fetch;

    logic        clk, rst, start, px_ready;
    logic [20:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] white_pixel, edge_thr, a_min, a_max, b_min, b_max, np_size, block_size;
    logic        px_valid, px_blk_first, px_blk_last, px_last, busy, done, cfg_err;
    logic [15:0] px_primary, px_wmark;

    logic [15:0] mem [0:255];
    logic [34:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    block_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .white_pixel  (white_pixel),
        .edge_thr     (edge_thr),
        .a_min        (a_min),
        .a_max        (a_max),
        .b_min        (b_min),
        .b_max        (b_max),
        .np_size      (np_size),
        .block_size   (block_size),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .px_primary   (px_primary),
        .px_wmark     (px_wmark),
        .px_blk_first (px_blk_first),
        .px_blk_last  (px_blk_last),
        .px_last      (px_last),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= (rd_addr < 21'd256) ? mem[rd_addr[7:0]] : 16'hDEAD;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input int np, input int nw, input int m);
        int nn;
        nn = np * np;
        mem[1] = 16'h00C8; mem[2] = 16'(np); mem[3] = 16'(nw); mem[4] = 16'(m);
        mem[5] = 16'h0030; mem[6] = 16'h0011; mem[7] = 16'h0022; mem[8] = 16'h0033; mem[9] = 16'h0044;
        if (nn <= 100) begin
            for (int i = 0; i < nn; i++) begin
                mem[10 + i]      = 16'(256 + i);
                mem[10 + nn + i] = 16'(512 + i);
            end
        end
    endtask

    // reference traversal: blocks row-major, then rows, then cols inside each block
    task automatic build(input int np, input int m);
        int nb, idx;
        logic [34:0] e;
        logic f, l, x;
        exp_q.delete();
        nb = np / m;
        for (int br = 0; br < nb; br++)
            for (int bc = 0; bc < nb; bc++)
                for (int r = 0; r < m; r++)
                    for (int c = 0; c < m; c++) begin
                        idx = (br * m + r) * np + bc * m + c;
                        f = (r == 0) && (c == 0);
                        l = (r == m - 1) && (c == m - 1);
                        x = l && (br == nb - 1) && (bc == nb - 1);
                        e = {16'(256 + idx), 16'(512 + idx), f, l, x};
                        exp_q.push_back(e);
                    end
    endtask

    task automatic consume(input int n, input int stall_at, input int stall_len, output int got, output int span);
        int waited, stalls, first_t, last_t;
        waited = 0; stalls = 0; got = 0; first_t = 0; last_t = 0;
        while (got < n && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (px_valid) begin
                if (got == stall_at && stalls < stall_len) begin
                    px_ready = 1'b0;
                    stalls++;
                end else begin
                    px_ready = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("extra_pair", 128'(1), 128'(0));
                    break;
                end
                check($sformatf("pair%0d", got),
                      128'({px_primary, px_wmark, px_blk_first, px_blk_last, px_last}), 128'(exp_q[0]));
                if (px_ready) begin
                    void'(exp_q.pop_front());
                    if (got == 0) first_t = waited;
                    last_t = waited;
                    got++;
                end
            end
        end
        px_ready = 1'b1;
        span = last_t - first_t;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!px_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(px_valid), 128'(1));
    endtask

    task automatic run_err(input int np, input int nw, input int m);
        int n;
        bit seen;
        setup(np, nw, m);
        start = 1'b1;
        n = 0; seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (px_valid) seen = 1'b1;
        end while (!cfg_err && n < 40);
        check($sformatf("err_lat_%0d_%0d_%0d", np, nw, m), 128'(n), 128'(12));
        check("err_noval", 128'(seen), 128'(0));
        check("err_busy", 128'(busy), 128'(0));
        start = 1'b0;
        @(negedge clk);
        check("err_clear", 128'({cfg_err, busy}), 128'(0));
    endtask

    task automatic finish_image(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 128'({done, busy, px_valid}), 128'(3'b100));
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 128'({done, busy}), 128'(0));
    endtask

    initial begin
        int got, span;
        int err_tab [6][3] = '{'{4, 4, 3}, '{4, 2, 2}, '{0, 0, 1}, '{4, 4, 0}, '{724, 724, 4}, '{2, 2, 4}};
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst = 1'b0; start = 1'b0; px_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a", 128'({rd_addr, np_size, block_size, edge_thr, a_min}), 128'(0));
        check("rst_b", 128'({a_max, b_min, b_max, px_primary, px_wmark}), 128'(0));
        check("rst_c", 128'({px_valid, px_blk_first, px_blk_last, px_last, busy, done, cfg_err}), 128'(0));
        check("rst_white", 128'(white_pixel), 128'(255));
        rst = 1'b1;
        @(negedge clk);

        setup(4, 4, 2); build(4, 2);
        start = 1'b1;
        consume(16, -1, 0, got, span);
        check("t1_count", 128'(got), 128'(16));
        check("t1_span", 128'(span), 128'(45));
        check("t1_cfg_a", 128'({white_pixel, np_size, block_size, edge_thr}), 128'(64'h00C8_0004_0002_0030));
        check("t1_cfg_b", 128'({a_min, a_max, b_min, b_max}), 128'(64'h0011_0022_0033_0044));
        repeat (3) @(negedge clk);
        check("t1_hold_done", 128'({done, busy}), 128'(2'b10));
        finish_image("t1");

        setup(4, 4, 2); build(4, 2);
        start = 1'b1;
        consume(16, 2, 5, got, span);
        check("t2_count", 128'(got), 128'(16));
        check("t2_span", 128'(span), 128'(50));
        finish_image("t2");

        for (int k = 0; k < 6; k++) run_err(err_tab[k][0], err_tab[k][1], err_tab[k][2]);

        setup(2, 2, 1); build(2, 1);
        start = 1'b1;
        consume(4, -1, 0, got, span);
        check("t4_m1_count", 128'(got), 128'(4));
        finish_image("t4_m1");

        setup(2, 2, 2); build(2, 2);
        start = 1'b1;
        consume(4, -1, 0, got, span);
        check("t4_mnp_count", 128'(got), 128'(4));
        finish_image("t4_mnp");

        setup(4, 4, 2); build(4, 2);
        start = 1'b1;
        consume(5, -1, 0, got, span);
        @(negedge clk);
        px_ready = 1'b0;
        wait_valid("t5_wait");
        start = 1'b0;
        #1;
        check("t5_drop_valid", 128'(px_valid), 128'(0));
        @(negedge clk);
        check("t5_abort", 128'({busy, px_valid, done}), 128'(0));
        px_ready = 1'b1;
        build(4, 2);
        start = 1'b1;
        consume(16, -1, 0, got, span);
        check("t5_restream", 128'(got), 128'(16));
        finish_image("t5");

        setup(4, 4, 2); build(4, 2);
        start = 1'b1;
        consume(2, -1, 0, got, span);
        @(negedge clk);
        px_ready = 1'b0;
        wait_valid("t6_wait");
        #2 rst = 1'b0;
        #1;
        check("t6_rst_a", 128'({rd_addr, np_size, block_size, edge_thr, a_min}), 128'(0));
        check("t6_rst_b", 128'({a_max, b_min, b_max, px_primary, px_wmark}), 128'(0));
        check("t6_rst_c", 128'({px_valid, px_blk_first, px_blk_last, px_last, busy, done, cfg_err}), 128'(0));
        check("t6_rst_white", 128'(white_pixel), 128'(255));
        start = 1'b0;
        px_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
